// File: rtl/decode_stage_fwd_pkg.sv
// decode_stage_fwd_pkg: MIPS decode constants, IR field helpers, encodings and operand use-table
package decode_stage_fwd_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2b;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_JR = 6'h08, FN_JALR = 6'h09;
  localparam logic [4:0] RT_BLTZ = 5'd0, RT_BGEZ = 5'd1;
  typedef enum logic [1:0] {NPC_SEQ = 2'd0, NPC_PC = 2'd1, NPC_REG = 2'd2} npc_sel_e;
  typedef enum logic [1:0] {EXT_SIGN = 2'd0, EXT_ZERO = 2'd1, EXT_UPPER = 2'd2} ext_op_e;
  function automatic logic [5:0] ir_op(input logic [31:0] ir); return ir[31:26]; endfunction
  function automatic logic [4:0] ir_rs(input logic [31:0] ir); return ir[25:21]; endfunction
  function automatic logic [4:0] ir_rt(input logic [31:0] ir); return ir[20:16]; endfunction
  function automatic logic [5:0] ir_fn(input logic [31:0] ir); return ir[5:0]; endfunction
  function automatic logic [15:0] ir_imm(input logic [31:0] ir); return ir[15:0]; endfunction
  function automatic logic uses_rs(input logic [31:0] ir);
    return ir_op(ir) == OP_RTYPE ? !(ir_fn(ir) inside {FN_SLL, FN_SRL, FN_SRA}) :
           ir_op(ir) inside {OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_ADDI, OP_ADDIU,
                             OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LB, OP_LH, OP_LW,
                             OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
  endfunction
  function automatic logic uses_rt(input logic [31:0] ir);
    return ir_op(ir) == OP_RTYPE ? !(ir_fn(ir) inside {FN_JR, FN_JALR}) :
           ir_op(ir) inside {OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW};
  endfunction
  function automatic ext_op_e ext_op(input logic [31:0] ir);
    return ir_op(ir) inside {OP_ANDI, OP_ORI, OP_XORI} ? EXT_ZERO :
           ir_op(ir) == OP_LUI ? EXT_UPPER : EXT_SIGN;
  endfunction
endpackage

// File: rtl/fwd_resolve.sv
// fwd_resolve: resolves one register operand through the forwarding network, W bypass and GRF
module fwd_resolve #(
  parameter int NFWD = 3,
  parameter int XLEN = 32
) (
  input  logic [4:0]           addr,
  input  logic [XLEN-1:0]      grf_val,
  input  logic [NFWD*5-1:0]    fwd_addr,
  input  logic [NFWD-1:0]      fwd_write,
  input  logic [NFWD-1:0]      fwd_ready,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic [4:0]           wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 wb_en,
  output logic [XLEN-1:0]      val,
  output logic                 hazard
);
  logic hit, rdy;
  logic [XLEN-1:0] fdat;
  // scanning oldest to youngest lets the youngest matching source overwrite the rest
  always_comb begin
    hit = 1'b0;
    rdy = 1'b0;
    fdat = '0;
    for (int i = NFWD - 1; i >= 0; i--)
      if (fwd_write[i] && fwd_addr[i*5 +: 5] == addr) begin
        hit = 1'b1;
        rdy = fwd_ready[i];
        fdat = fwd_data[i*XLEN +: XLEN];
      end
  end
  assign hazard = addr != '0 && hit && !rdy;
  assign val = addr == '0 ? '0 : hit ? fdat : (wb_en && wb_addr == addr) ? wb_data : grf_val;
endmodule

// File: rtl/decode_stage_fwd.sv
// decode_stage_fwd: MIPS D stage with GRF, forwarding, load-use stall, branch resolve and D/E register
module decode_stage_fwd #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NFWD = 3,
  parameter int CNTW = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [31:0]          IRD,
  input  logic [XLEN-1:0]      PC4D,
  input  logic                 ValidD,
  input  logic                 FlushE,
  input  logic [NFWD*5-1:0]    FwdAddr,
  input  logic [NFWD-1:0]      FwdWrite,
  input  logic [NFWD-1:0]      FwdReady,
  input  logic [NFWD*XLEN-1:0] FwdData,
  input  logic [4:0]           WbAddr,
  input  logic [XLEN-1:0]      WbData,
  input  logic                 WbEn,
  output logic                 StallD,
  output logic                 Branch,
  output logic [1:0]           NPC_Sel,
  output logic [XLEN-1:0]      NPC,
  output logic [31:0]          IRE,
  output logic [XLEN-1:0]      PC4E,
  output logic [XLEN-1:0]      RSE,
  output logic [XLEN-1:0]      RTE,
  output logic [XLEN-1:0]      EXTE,
  output logic                 ValidE,
  output logic [CNTW-1:0]      StallCnt
);
  import decode_stage_fwd_pkg::*;
  localparam int AW = $clog2(NREG);
  logic [XLEN-1:0] grf [NREG];
  logic [XLEN-1:0] rs_val, rt_val, sext, ext, br_tgt, j_tgt;
  logic [5:0] op;
  logic [4:0] rs, rt;
  logic [15:0] imm;
  logic rs_haz, rt_haz, neg, zero, is_jr, taken, bubble;
  ext_op_e eop;
  assign op = ir_op(IRD);
  assign rs = ir_rs(IRD);
  assign rt = ir_rt(IRD);
  assign imm = ir_imm(IRD);
  assign eop = ext_op(IRD);
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) grf <= '{default: '0};
    else if (WbEn && WbAddr[AW-1:0] != '0) grf[WbAddr[AW-1:0]] <= WbData;
  fwd_resolve #(.NFWD(NFWD), .XLEN(XLEN)) u_rs (
    .addr(rs), .grf_val(grf[rs[AW-1:0]]), .fwd_addr(FwdAddr), .fwd_write(FwdWrite),
    .fwd_ready(FwdReady), .fwd_data(FwdData), .wb_addr(WbAddr), .wb_data(WbData),
    .wb_en(WbEn), .val(rs_val), .hazard(rs_haz)
  );
  fwd_resolve #(.NFWD(NFWD), .XLEN(XLEN)) u_rt (
    .addr(rt), .grf_val(grf[rt[AW-1:0]]), .fwd_addr(FwdAddr), .fwd_write(FwdWrite),
    .fwd_ready(FwdReady), .fwd_data(FwdData), .wb_addr(WbAddr), .wb_data(WbData),
    .wb_en(WbEn), .val(rt_val), .hazard(rt_haz)
  );
  assign StallD = ValidD && ((uses_rs(IRD) && rs_haz) || (uses_rt(IRD) && rt_haz));
  assign sext = XLEN'($signed(imm));
  assign ext = eop == EXT_ZERO ? XLEN'(imm) : eop == EXT_UPPER ? XLEN'($signed({imm, 16'h0000})) : sext;
  assign neg = rs_val[XLEN-1];
  assign zero = rs_val == '0;
  assign is_jr = op == OP_RTYPE && ir_fn(IRD) inside {FN_JR, FN_JALR};
  assign taken = op == OP_BEQ ? rs_val == rt_val :
                 op == OP_BNE ? rs_val != rt_val :
                 op == OP_BLEZ ? neg || zero :
                 op == OP_BGTZ ? !neg && !zero :
                 op == OP_REGIMM ? (rt == RT_BLTZ ? neg : rt == RT_BGEZ ? !neg : 1'b0) :
                 op inside {OP_J, OP_JAL} || is_jr;
  assign Branch = ValidD && !StallD && taken;
  assign NPC_Sel = !Branch ? NPC_SEQ : is_jr ? NPC_REG : NPC_PC;
  assign br_tgt = PC4D + {sext[XLEN-3:0], 2'b00};
  assign j_tgt = {PC4D[XLEN-1:28], IRD[25:0], 2'b00};
  assign NPC = is_jr ? rs_val : op inside {OP_J, OP_JAL} ? j_tgt : br_tgt;
  assign bubble = FlushE || StallD || !ValidD;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      IRE <= '0;
      PC4E <= '0;
      RSE <= '0;
      RTE <= '0;
      EXTE <= '0;
      ValidE <= 1'b0;
      StallCnt <= '0;
    end else begin
      IRE <= bubble ? '0 : IRD;
      PC4E <= bubble ? '0 : PC4D;
      RSE <= bubble ? '0 : rs_val;
      RTE <= bubble ? '0 : rt_val;
      EXTE <= bubble ? '0 : ext;
      ValidE <= !bubble;
      if (StallD && !(&StallCnt)) StallCnt <= StallCnt + 1'b1;
    end
endmodule

// File: tb/tb_decode_stage_fwd.sv
// tb_decode_stage_fwd: directed checks of operand resolve, stalls, branches and D/E register
module tb_decode_stage_fwd;
  logic Clk = 1'b0, Reset, ValidD, FlushE, WbEn;
  logic [31:0] IRD, PC4D, WbData, NPC, PC4E, RSE, RTE, EXTE, IRE;
  logic [14:0] FwdAddr;
  logic [2:0] FwdWrite, FwdReady;
  logic [95:0] FwdData;
  logic [4:0] WbAddr;
  logic StallD, Branch, ValidE;
  logic [1:0] NPC_Sel, StallCnt;
  int errors = 0, checks = 0;
  decode_stage_fwd #(.XLEN(32), .NREG(32), .NFWD(3), .CNTW(2)) dut (
    .Clk(Clk), .Reset(Reset), .IRD(IRD), .PC4D(PC4D), .ValidD(ValidD), .FlushE(FlushE),
    .FwdAddr(FwdAddr), .FwdWrite(FwdWrite), .FwdReady(FwdReady), .FwdData(FwdData),
    .WbAddr(WbAddr), .WbData(WbData), .WbEn(WbEn), .StallD(StallD), .Branch(Branch),
    .NPC_Sel(NPC_Sel), .NPC(NPC), .IRE(IRE), .PC4E(PC4E), .RSE(RSE), .RTE(RTE),
    .EXTE(EXTE), .ValidE(ValidE), .StallCnt(StallCnt)
  );
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask
  task automatic idle;
    IRD = '0; PC4D = '0; ValidD = 1'b0; FlushE = 1'b0;
    FwdAddr = '0; FwdWrite = '0; FwdReady = '0; FwdData = '0;
    WbAddr = '0; WbData = '0; WbEn = 1'b0;
  endtask
  function automatic logic [31:0] r_ins(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    Reset = 1'b0;
    idle();
    repeat (2) @(posedge Clk);
    #1;
    check("rst_ire", IRE, 0);
    check("rst_valid", ValidE, 0);
    check("rst_cnt", StallCnt, 0);
    Reset = 1'b1;
    tick();
    // same-cycle write and read of $5
    IRD = r_ins(5'd5, 5'd0, 5'd1, 6'h20); PC4D = 32'h1004; ValidD = 1'b1;
    WbEn = 1'b1; WbAddr = 5'd5; WbData = 32'h1234;
    tick();
    check("wbr_rse", RSE, 32'h1234);
    check("wbr_valid", ValidE, 1);
    check("wbr_pc4", PC4E, 32'h1004);
    check("wbr_ire", IRE, r_ins(5'd5, 5'd0, 5'd1, 6'h20));
    WbEn = 1'b0;
    tick();
    check("grf_rse", RSE, 32'h1234);
    IRD = r_ins(5'd0, 5'd0, 5'd1, 6'h20);
    WbEn = 1'b1; WbAddr = 5'd0; WbData = 32'hdead;
    tick();
    check("r0_bypass", RTE, 0);
    WbEn = 1'b0;
    tick();
    check("r0_grf", RSE, 0);
    // forwarding priority: source 1 beats source 2, source 0 not writing
    IRD = r_ins(5'd5, 5'd5, 5'd1, 6'h20);
    FwdAddr = {5'd5, 5'd5, 5'd5}; FwdWrite = 3'b110; FwdReady = 3'b101;
    FwdData = {32'hcccc_0003, 32'hbbbb_0002, 32'haaaa_0001};
    #1 check("prio_stall", StallD, 1);
    FwdReady = 3'b111;
    #1 check("prio_nostall", StallD, 0);
    tick();
    check("prio_rse", RSE, 32'hbbbb_0002);
    check("prio_rte", RTE, 32'hbbbb_0002);
    // ori does not read rt, so a pending hazard on it must not stall
    IRD = i_ins(6'h0d, 5'd0, 5'd5, 16'hffff);
    FwdAddr = {5'd0, 5'd0, 5'd5}; FwdWrite = 3'b001; FwdReady = 3'b000;
    #1 check("use_nostall", StallD, 0);
    tick();
    check("ori_ext", EXTE, 32'h0000_ffff);
    // load-use stall, flushed in the same cycle
    IRD = r_ins(5'd8, 5'd8, 5'd9, 6'h20);
    FwdAddr = {5'd0, 5'd0, 5'd8}; FwdWrite = 3'b001; FwdReady = 3'b000;
    FwdData = {64'd0, 32'h55}; FlushE = 1'b1;
    #1 check("lu_stall", StallD, 1);
    tick();
    check("lu_valid", ValidE, 0);
    check("lu_ire", IRE, 0);
    check("lu_cnt", StallCnt, 1);
    FlushE = 1'b0; FwdReady = 3'b001;
    #1 check("lu_go", StallD, 0);
    tick();
    check("lu_valid2", ValidE, 1);
    check("lu_rse", RSE, 32'h55);
    check("lu_cnt_hold", StallCnt, 1);
    // branches and jumps
    FwdAddr = {5'd0, 5'd3, 5'd2}; FwdWrite = 3'b011; FwdReady = 3'b011;
    FwdData = {32'd0, 32'h8000_0000, 32'h8000_0000};
    IRD = i_ins(6'h04, 5'd2, 5'd3, 16'hffff); PC4D = 32'h3004;
    #1 check("beq_br", Branch, 1);
    check("beq_npc", NPC, 32'h3000);
    check("beq_sel", NPC_Sel, 1);
    tick();
    check("beq_ext", EXTE, 32'hffff_ffff);
    IRD = i_ins(6'h07, 5'd2, 5'd0, 16'h0004);
    #1 check("bgtz_br", Branch, 0);
    check("bgtz_sel", NPC_Sel, 0);
    IRD = {6'h02, 26'h000_0100};
    #1 check("j_br", Branch, 1);
    check("j_npc", NPC, 32'h0000_0400);
    IRD = r_ins(5'd2, 5'd0, 5'd0, 6'h08);
    #1 check("jr_npc", NPC, 32'h8000_0000);
    check("jr_sel", NPC_Sel, 2);
    IRD = i_ins(6'h0f, 5'd0, 5'd1, 16'h8001);
    tick();
    check("lui_ext", EXTE, 32'h8001_0000);
    IRD = i_ins(6'h04, 5'd2, 5'd3, 16'hffff); FwdReady = 3'b010;
    #1 check("stall_br", Branch, 0);
    check("stall_sel", NPC_Sel, 0);
    check("stall_d", StallD, 1);
    // counter saturation (CNTW = 2)
    repeat (5) tick();
    check("cnt_sat", StallCnt, 3);
    FwdWrite = 3'b000; IRD = r_ins(5'd5, 5'd0, 5'd1, 6'h20); PC4D = 32'h2004; FlushE = 1'b1;
    tick();
    check("flush_valid", ValidE, 0);
    check("flush_ire", IRE, 0);
    FlushE = 1'b0;
    tick();
    check("post_flush_rse", RSE, 32'h1234);
    check("post_flush_valid", ValidE, 1);
    // asynchronous reset in the middle of a stall
    FwdAddr = {5'd0, 5'd0, 5'd5}; FwdWrite = 3'b001; FwdReady = 3'b000;
    #2 Reset = 1'b0;
    #1 check("mrst_rse", RSE, 0);
    check("mrst_pc4", PC4E, 0);
    check("mrst_valid", ValidE, 0);
    check("mrst_cnt", StallCnt, 0);
    @(posedge Clk);
    #1 Reset = 1'b1;
    idle();
    IRD = r_ins(5'd5, 5'd0, 5'd1, 6'h20); ValidD = 1'b1;
    tick();
    check("mrst_grf", RSE, 0);
    check("mrst_cnt2", StallCnt, 0);
    check("mrst_valid2", ValidE, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
